// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: turns a valid/ready command into one
// SINGLE NONSEQ transfer and returns a one-cycle completion pulse.
// Optional feature: define AHB_MASTER_ALIGN_CHECK_EN to reject reserved-size
// and misaligned commands locally with an error response, without a bus transfer.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [31:0] cmdAddr,
    input  logic [1:0]  cmdSize,
    input  logic [31:0] cmdWData,
    output logic        rspValid,
    output logic        rspErr,
    output logic [31:0] rspRData,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] wdata_q;
    logic        accept;
    logic        cmd_bad;

    // Replicate narrow write data across every byte lane so any slave lane
    // decoding sees the right value regardless of address offset.
    function automatic logic [31:0] lane_rep(input logic [1:0] size,
                                             input logic [31:0] d);
        case (size)
            2'd0:    lane_rep = {4{d[7:0]}};
            2'd1:    lane_rep = {2{d[15:0]}};
            default: lane_rep = d;
        endcase
    endfunction

`ifdef AHB_MASTER_ALIGN_CHECK_EN
    // Reserved size or an address not aligned to the transfer size.
    assign cmd_bad = (cmdSize == 2'd3) ||
                     ((cmdSize == 2'd1) && cmdAddr[0]) ||
                     ((cmdSize == 2'd2) && (cmdAddr[1:0] != 2'b00));
`else
    assign cmd_bad = 1'b0;
`endif

    assign accept    = cmdValid && cmdReady;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VALUE;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and phase-dependent outputs; wait states simply hold the phase.
    always_comb begin
        state_next = state;
        cmdReady   = 1'b0;
        HTRANS     = 2'b00;
        case (state)
            IDLE: begin
                cmdReady = !HRESET;
                if (cmdValid && !HRESET && !cmd_bad) state_next = ADDR;
            end
            ADDR: begin
                HTRANS = 2'b10;
                if (HREADY) state_next = DATA;
            end
            DATA: begin
                if (HREADY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture, write-data launch and completion reporting.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR    <= 32'd0;
            HWRITE   <= 1'b0;
            HSIZE    <= 3'd0;
            HWDATA   <= 32'd0;
            wdata_q  <= 32'd0;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspRData <= 32'd0;
        end else begin
            rspValid <= 1'b0;
            if (accept && !cmd_bad) begin
                HADDR   <= cmdAddr;
                HWRITE  <= cmdWrite;
                HSIZE   <= {1'b0, cmdSize};
                wdata_q <= lane_rep(cmdSize, cmdWData);
            end
            if (accept && cmd_bad) begin
                rspValid <= 1'b1;
                rspErr   <= 1'b1;
            end
            if ((state == ADDR) && HREADY) HWDATA <= wdata_q;
            if ((state == DATA) && HREADY) begin
                rspValid <= 1'b1;
                rspErr   <= HRESP;
                if (!HWRITE) rspRData <= HRDATA;
            end
        end
    end

endmodule
